// File: rtl/trcal_measure_pkg.sv
// -----------------------------------------------------------------------------
// trcal_measure_pkg
// Shared definitions for the reader-preamble calibration measurement block:
// FSM state encoding, the cycle-counter width, its saturation value and the
// default minimum delimiter length.
// -----------------------------------------------------------------------------
package trcal_measure_pkg;

  // Width of the rise-to-rise cycle counter and of all measured lengths.
  localparam int CNT_W = 10;

  // Counter ceiling; reaching it inside a symbol means the preamble stalled.
  localparam logic [CNT_W-1:0] CNT_SAT = 10'd1023;

  // Default minimum delimiter low time, in oscclk cycles.
  localparam logic [CNT_W-1:0] DELIM_MIN_DEFAULT = 10'd8;

  typedef enum logic [2:0] {
    ST_IDLE,      // waiting for the delimiter falling edge
    ST_DELIM,     // timing the delimiter low period
    ST_DATA0,     // skipping the data-0 symbol
    ST_RTCAL,     // measuring RTcal
    ST_CLASSIFY   // measuring the next symbol, TRcal or data
  } state_e;

endpackage

// File: rtl/trcal_edgedet.sv
// -----------------------------------------------------------------------------
// trcal_edgedet
// Registers the demodulated envelope and produces one-cycle rise/fall pulses
// by comparing the current and previous registered samples.
//
// Build option: define TRCAL_MEASURE_SYNC_EN to insert a two-flop
// synchronizer ahead of the sampling stage (two extra cycles of latency;
// edge-to-edge spacing is unchanged).
//
// Ports:
//   oscclk  : clock, all state updates on the rising edge
//   reset   : synchronous, active-high; samples reset to 1 (carrier)
//   demodin : demodulated envelope, 1 = carrier, 0 = PIE low pulse
//   rise    : one-cycle pulse on a registered 0->1 transition
//   fall    : one-cycle pulse on a registered 1->0 transition
// -----------------------------------------------------------------------------
module trcal_edgedet (
  input  logic oscclk,
  input  logic reset,
  input  logic demodin,
  output logic rise,
  output logic fall
);

  logic stage_in;
  logic smp_q;
  logic prev_q;

`ifdef TRCAL_MEASURE_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge oscclk) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      // NOTE: non-blocking assignments make each flop capture the value its
      // predecessor held before the edge, so the chain really is two stages.
      sync_q <= {sync_q[0], demodin};
    end
  end

  assign stage_in = sync_q[1];
`else
  assign stage_in = demodin;
`endif

  // Samples reset to carrier so that a reset never manufactures an edge.
  always_ff @(posedge oscclk) begin
    if (reset) begin
      smp_q  <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      smp_q  <= stage_in;
      prev_q <= smp_q;
    end
  end

  assign rise =  smp_q & ~prev_q;
  assign fall = ~smp_q &  prev_q;

endmodule

// File: rtl/trcal_measure.sv
// -----------------------------------------------------------------------------
// trcal_measure
// Measures the RTcal and (optional) TRcal symbols of a reader preamble or
// frame-sync. Lengths are rise-to-rise distances in oscclk cycles.
// Sequence: delimiter (low >= DELIM_MIN) -> data-0 (ignored) -> RTcal ->
// one more symbol, classified as TRcal when longer than RTcal.
//
// Build option: TRCAL_MEASURE_SYNC_EN adds a two-flop input synchronizer
// inside trcal_edgedet.
//
// Parameters:
//   DELIM_MIN     : minimum delimiter low time, oscclk cycles
// Ports:
//   oscclk        : sole clock
//   reset         : synchronous, active-high, dominates everything
//   demodin       : demodulated envelope (1 = carrier)
//   rtcal         : last measured RTcal length
//   trcal         : last measured TRcal length (tx clock divider input)
//   trcal_present : 1 when the last preamble carried a TRcal symbol
//   cal_valid     : one-cycle pulse when the three results update
//   cal_error     : one-cycle pulse when a preamble is aborted on timeout
// -----------------------------------------------------------------------------
module trcal_measure
  import trcal_measure_pkg::*;
#(
  parameter logic [CNT_W-1:0] DELIM_MIN = DELIM_MIN_DEFAULT
) (
  input  logic             oscclk,
  input  logic             reset,
  input  logic             demodin,
  output logic [CNT_W-1:0] rtcal,
  output logic [CNT_W-1:0] trcal,
  output logic             trcal_present,
  output logic             cal_valid,
  output logic             cal_error
);

  logic rise;
  logic fall;

  state_e           state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [CNT_W-1:0] rtcal_meas_q, rtcal_meas_d;
  logic [CNT_W-1:0] rtcal_q,      rtcal_d;
  logic [CNT_W-1:0] trcal_q,      trcal_d;
  logic             present_q,    present_d;
  logic             valid_q,      valid_d;
  logic             error_q,      error_d;

  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_sat;

  trcal_edgedet u_edgedet (
    .oscclk  (oscclk),
    .reset   (reset),
    .demodin (demodin),
    .rise    (rise),
    .fall    (fall)
  );

  assign cnt_sat = (cnt_q == CNT_SAT);
  assign cnt_inc = cnt_sat ? CNT_SAT : cnt_q + CNT_W'(1);

  // Counting restarts at 1 on every rise pulse, so on the next rise pulse
  // the counter equals the cycle-index difference between the two rises.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_inc;
    rtcal_meas_d = rtcal_meas_q;
    rtcal_d      = rtcal_q;
    trcal_d      = trcal_q;
    present_d    = present_q;
    valid_d      = 1'b0;
    error_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (fall) state_d = ST_DELIM;
      end

      ST_DELIM: begin
        // A too-short low pulse is just noise: quietly return to IDLE.
        if (rise) begin
          cnt_d   = CNT_W'(1);
          state_d = (cnt_q >= DELIM_MIN) ? ST_DATA0 : ST_IDLE;
        end
      end

      ST_DATA0: begin
        if (cnt_sat) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else if (rise) begin
          cnt_d   = CNT_W'(1);
          state_d = ST_RTCAL;
        end
      end

      ST_RTCAL: begin
        if (cnt_sat) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else if (rise) begin
          rtcal_meas_d = cnt_q;
          cnt_d        = CNT_W'(1);
          state_d      = ST_CLASSIFY;
        end
      end

      ST_CLASSIFY: begin
        if (cnt_sat) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else if (rise) begin
          // Only a symbol longer than RTcal can be TRcal; a data symbol
          // leaves the previous trcal in place for the tx divider.
          if (cnt_q > rtcal_meas_q) begin
            trcal_d   = cnt_q;
            present_d = 1'b1;
          end else begin
            present_d = 1'b0;
          end
          rtcal_d = rtcal_meas_q;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge oscclk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      rtcal_meas_q <= '0;
      rtcal_q      <= '0;
      trcal_q      <= '0;
      present_q    <= 1'b0;
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rtcal_meas_q <= rtcal_meas_d;
      rtcal_q      <= rtcal_d;
      trcal_q      <= trcal_d;
      present_q    <= present_d;
      valid_q      <= valid_d;
      error_q      <= error_d;
    end
  end

  assign rtcal         = rtcal_q;
  assign trcal         = trcal_q;
  assign trcal_present = present_q;
  assign cal_valid     = valid_q;
  assign cal_error     = error_q;

endmodule

// File: doc/trcal_measure.md
TRCAL_MEASURE -- requirements
Module: trcal_measure

Interface
REQ-001 SHALL have parameter DELIM_MIN, default 10'd8: minimum delimiter low time in oscclk cycles.
REQ-002 SHALL have port oscclk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port demodin  input  1  demodulated reader envelope: 1 = carrier, 0 = PIE low pulse.
REQ-005 SHALL have port rtcal  output  10  last measured RTcal length, in oscclk cycles.
REQ-006 SHALL have port trcal  output  10  last measured TRcal length, in oscclk cycles; feeds the tx clock divider.
REQ-007 SHALL have port trcal_present  output  1  1 when the last preamble contained a TRcal symbol.
REQ-008 SHALL have port cal_valid  output  1  one-cycle pulse when rtcal/trcal/trcal_present update.
REQ-009 SHALL have port cal_error  output  1  one-cycle pulse on an aborted preamble.

Function
REQ-010 SHALL register demodin through the input stage, then derive one-cycle rise/fall pulses by comparing the current and previous registered samples.
REQ-011 SHALL implement states IDLE, DELIM, DATA0, RTCAL, CLASSIFY.
REQ-012 IDLE: on fall pulse -> DELIM; clear the counter.
REQ-013 DELIM: count cycles while low; on rise pulse, if count >= DELIM_MIN -> DATA0, else -> IDLE with no cal_error pulse.
REQ-014 DATA0: on rise pulse -> RTCAL; data-0 length is not stored.
REQ-015 RTCAL: on rise pulse, latch the internal rtcal_meas = cycles since previous rise pulse -> CLASSIFY.
REQ-016 CLASSIFY: on rise pulse, if the symbol length is strictly greater than rtcal_meas, treat it as TRcal: trcal <= length, trcal_present <= 1; otherwise trcal holds its value and trcal_present <= 0. In both cases rtcal <= rtcal_meas, pulse cal_valid, then -> IDLE.
REQ-017 Symbol length SHALL equal the difference in cycle index between consecutive rise pulses (rise at cycles 100 and 130 -> 30).
REQ-018 Outputs SHALL update in the cycle after the rise pulse that completes the measurement.
REQ-019 Counter is 10 bits and SHALL saturate at 1023; reaching 1023 in DATA0, RTCAL or CLASSIFY -> pulse cal_error, -> IDLE, outputs unchanged.
REQ-020 A fall pulse in any non-IDLE state SHALL only be ignored; measurement is rising-to-rising.
REQ-021 rtcal, trcal and trcal_present SHALL hold between updates.

Reset
REQ-022 Reset SHALL dominate all other events in the same cycle.
REQ-023 Reset values: state IDLE, counter 0, rtcal 0, trcal 0, trcal_present 0, cal_valid 0, cal_error 0, input registers 1 (carrier).
REQ-024 Reset mid-preamble SHALL discard the partial measurement with no cal_valid or cal_error pulse.

Configuration
REQ-025 With TRCAL_MEASURE_SYNC_EN defined, demodin SHALL pass through a two-flop synchronizer before edge detection, giving 2 extra cycles of latency. Edge-to-edge lengths are unchanged.
REQ-026 Without TRCAL_MEASURE_SYNC_EN, demodin SHALL be registered once only.

Structure
REQ-027 A shared package SHALL hold the state enum, the 10-bit count width constant, the saturation value 1023 and the DELIM_MIN default.
REQ-028 Edge detection plus the optional synchronizer SHALL be one sub-module, trcal_edgedet.

Verification
REQ-029 Bench SHALL drive: delimiter 12 low, data0 rise gap 20, RTcal gap 50, TRcal gap 120 -> rtcal=50, trcal=120, trcal_present=1, cal_valid one pulse.
REQ-030 Bench SHALL drive: same sequence with last gap 25 (data symbol) -> rtcal=50, trcal holds 120, trcal_present=0.
REQ-031 Bench SHALL drive: delimiter low 5 cycles (< DELIM_MIN) -> no cal_valid, no cal_error, back to IDLE; next valid preamble measures correctly.
REQ-032 Bench SHALL drive: a valid delimiter, then demodin held high 1100 cycles in RTCAL -> cal_error pulse at count 1023, outputs unchanged.
REQ-033 Bench SHALL assert reset during CLASSIFY -> no pulses, all outputs 0 next cycle.
REQ-034 Bench SHALL run REQ-029 with and without TRCAL_MEASURE_SYNC_EN -> identical values, cal_valid 2 cycles later when the macro is defined.
